dcmac_0_axis_pkt_mon_seg_compact: RTL and testbench

Parametrised segment-compaction stage for the DCMAC AXIS packet monitor. It takes one segmented LBUS beat per cycle and removes the empty (mty) bytes at every end-of-packet segment. It emits the compacted bytes, the beat byte count and, optionally, per-group completed-packet lengths tracked per channel ID. It sits between the LBUS capture register and the monitor's CRC/statistics logic, and generalises the fixed 12-segment merge to any segment/group count with a valid qualifier.

---
 rtl/dcmac_0_axis_pkt_mon_seg_compact.sv | 258 +++++++++++++++++++++++++
 tb/tb_dcmac_0_axis_pkt_mon_seg_compact.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcmac_0_axis_pkt_mon_seg_compact.sv
// Segment compaction for the DCMAC AXIS packet monitor: strips mty bytes at eop segments.
// Optional per-ID packet length tracking is built when DCMAC_PKT_MON_LEN_TRACK_EN is defined.
module dcmac_0_axis_pkt_mon_seg_compact #(
  parameter  int NUM_SEG     = 12,
  parameter  int SEG_PER_GRP = 4,
  parameter  int NUM_ID      = 6,
  parameter  int LEN_W       = 16,
  localparam int ID_W        = (NUM_ID == 1) ? 1 : $clog2(NUM_ID),
  localparam int NUM_GRP     = NUM_SEG / SEG_PER_GRP,
  localparam int SZ_W        = $clog2(NUM_SEG*16+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_vld,
  input  logic [ID_W-1:0]            i_id,
  input  logic [NUM_SEG-1:0]         i_ena,
  input  logic [NUM_SEG-1:0]         i_sop,
  input  logic [NUM_SEG-1:0]         i_eop,
  input  logic [NUM_SEG-1:0]         i_err,
  input  logic [NUM_SEG*4-1:0]       i_mty,
  input  logic [NUM_SEG*128-1:0]     i_dat,
  output logic                       o_vld,
  output logic [ID_W-1:0]            o_id,
  output logic [SZ_W-1:0]            o_size,
  output logic [NUM_SEG*128-1:0]     o_dat,
  output logic                       o_proto_err,
  output logic [NUM_GRP-1:0]         o_pkt_vld,
  output logic [NUM_GRP*LEN_W-1:0]   o_pkt_len,
  output logic [NUM_GRP-1:0]         o_pkt_err
);

  localparam int NB    = NUM_SEG * 16;
  localparam int DW    = NB * 8;
  localparam int SEL_W = $clog2(NUM_GRP + 1);
  localparam int CW    = 1 + ID_W + 1 + NUM_GRP + NUM_GRP*LEN_W + NUM_GRP;

  // ---------------- stage 0: effective eops, segment lengths, protocol check
  logic [NUM_SEG-1:0]      eop_c;
  logic [NUM_GRP-1:0]      multi_c;
  logic [NUM_SEG-1:0][4:0] len_c;
  logic                    proto_c;

  for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp
    logic [SEG_PER_GRP-1:0] ee;
    assign ee = i_ena[gi*SEG_PER_GRP +: SEG_PER_GRP] & i_eop[gi*SEG_PER_GRP +: SEG_PER_GRP];
    // Only the lowest eop of a group counts; extra ones are a protocol error.
    assign eop_c[gi*SEG_PER_GRP +: SEG_PER_GRP] = ee & ~(ee - SEG_PER_GRP'(1));
    assign multi_c[gi] = (ee & (ee - SEG_PER_GRP'(1))) != '0;
  end

  for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_len
    assign len_c[gi] = !i_ena[gi] ? 5'd0 :
                       eop_c[gi]  ? 5'd16 - {1'b0, i_mty[gi*4 +: 4]} : 5'd16;
  end

  assign proto_c = (|multi_c) | ((i_ena & (i_ena + NUM_SEG'(1))) != '0);

  logic [NUM_GRP-1:0]       pv_c;
  logic [NUM_GRP*LEN_W-1:0] pl_c;
  logic [NUM_GRP-1:0]       pe_c;

`ifdef DCMAC_PKT_MON_LEN_TRACK_EN
  localparam int NSLOT = 1 << ID_W;
  logic [LEN_W-1:0] acc_q [NSLOT];
  logic [NSLOT-1:0] open_q;
  logic [NSLOT-1:0] perr_q;
  logic [LEN_W-1:0] run_len;
  logic             run_open;
  logic             run_err;
  logic [LEN_W:0]   sum;

  always_comb begin
    run_len  = acc_q[i_id];
    run_open = open_q[i_id];
    run_err  = perr_q[i_id];
    sum      = '0;
    pv_c     = '0;
    pl_c     = '0;
    pe_c     = '0;
    for (int s = 0; s < NUM_SEG; s++) begin
      if (i_ena[s]) begin
        if (i_sop[s]) begin
          run_err  = run_open | i_err[s];
          run_len  = LEN_W'(len_c[s]);
          run_open = 1'b1;
        end else begin
          sum = {1'b0, run_len} + (LEN_W+1)'(len_c[s]);
          if (sum[LEN_W]) begin
            run_len = '1;
            run_err = 1'b1;
          end else begin
            run_len = sum[LEN_W-1:0];
          end
          run_err = run_err | i_err[s];
        end
        if (eop_c[s]) begin
          pv_c[s/SEG_PER_GRP]                 = ~proto_c;
          pl_c[(s/SEG_PER_GRP)*LEN_W +: LEN_W] = proto_c ? '0 : run_len;
          pe_c[s/SEG_PER_GRP]                 = ~proto_c & (run_err | ~run_open);
          run_len  = '0;
          run_open = 1'b0;
          run_err  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NSLOT; n++) acc_q[n] <= '0;
      open_q <= '0;
      perr_q <= '0;
    end else if (i_vld && !proto_c) begin
      acc_q[i_id]  <= run_len;
      open_q[i_id] <= run_open;
      perr_q[i_id] <= run_err;
    end
  end
`else
  logic unused_len_track;
  assign unused_len_track = ^{i_sop, i_err};
  assign pv_c = '0;
  assign pl_c = '0;
  assign pe_c = '0;
`endif

  // ---------------- control pipeline (valid, id, flags, packet results)
  logic [CW-1:0] ctrl_c;
  logic [CW-1:0] ctrl_q [4];

  assign ctrl_c = {i_vld, (i_vld ? i_id : {ID_W{1'b0}}), i_vld & proto_c,
                   (i_vld ? pv_c : {NUM_GRP{1'b0}}), (i_vld ? pl_c : {NUM_GRP*LEN_W{1'b0}}),
                   (i_vld ? pe_c : {NUM_GRP{1'b0}})};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) ctrl_q[n] <= '0;
    end else begin
      ctrl_q[0] <= ctrl_c;
      for (int n = 1; n < 4; n++) ctrl_q[n] <= ctrl_q[n-1];
    end
  end

  // ---------------- datapath stages 1..4 (no reset needed, qualified by ctrl valid)
  logic [DW-1:0]             dat1_q, dat2_q, dat3_q;
  logic [NUM_SEG-1:0][4:0]   len1_q;
  logic [NUM_SEG-1:0]        eop1_q;
  logic [NUM_SEG*4-1:0]      mty1_q;
  logic [NUM_GRP:0][SZ_W-1:0] cm_c, cm2_q, cm3_q;
  logic [NUM_GRP-1:0][SZ_W-1:0] bnd_c, bnd2_q, gend_c;
  logic [NUM_GRP-1:0][3:0]   gmty_c;
  logic [SZ_W-1:0]           size_c, size2_q, size3_q, size4_q;
  logic [NB-1:0][SEL_W-1:0]  sel_c, sel3_q;
  logic [NUM_GRP:0][DW-1:0]  stg_c;
  logic [DW-1:0]             cmp_c, cmp4_q, mask_c;

  // Cumulative mty ahead of each group, and where each group's pre-eop region ends.
  always_comb begin
    cm_c[0] = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      gmty_c[g] = '0;
      gend_c[g] = SZ_W'((g+1)*SEG_PER_GRP*16);
      for (int k = 0; k < SEG_PER_GRP; k++) begin
        if (eop1_q[g*SEG_PER_GRP+k]) begin
          gmty_c[g] = mty1_q[(g*SEG_PER_GRP+k)*4 +: 4];
          gend_c[g] = SZ_W'((g*SEG_PER_GRP+k+1)*16);
        end
      end
      cm_c[g+1] = cm_c[g] + SZ_W'(gmty_c[g]);
      bnd_c[g]  = gend_c[g] - cm_c[g+1];
    end
    size_c = '0;
    for (int s = 0; s < NUM_SEG; s++) size_c = size_c + SZ_W'(len1_q[s]);
  end

  // Output byte j takes shift stage = number of boundaries at or below j.
  always_comb begin
    sel_c = '0;
    for (int j = 0; j < NB; j++) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        if (SZ_W'(j) >= bnd2_q[g]) sel_c[j] = sel_c[j] + SEL_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi <= NUM_GRP; gi++) begin : g_stg
    assign stg_c[gi] = dat3_q >> {cm3_q[gi], 3'b000};
  end

  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    assign cmp_c[gi*8 +: 8]  = stg_c[sel3_q[gi]][gi*8 +: 8];
    assign mask_c[gi*8 +: 8] = (SZ_W'(gi) < size4_q) ? cmp4_q[gi*8 +: 8] : 8'h00;
  end

  always_ff @(posedge clk) begin
    dat1_q  <= i_dat;
    len1_q  <= len_c;
    eop1_q  <= eop_c;
    mty1_q  <= i_mty;
    dat2_q  <= dat1_q;
    cm2_q   <= cm_c;
    bnd2_q  <= bnd_c;
    size2_q <= size_c;
    dat3_q  <= dat2_q;
    cm3_q   <= cm2_q;
    sel3_q  <= sel_c;
    size3_q <= size2_q;
    cmp4_q  <= cmp_c;
    size4_q <= size3_q;
  end

  // ---------------- stage 5: registered outputs
  logic                     c_vld, c_proto;
  logic [ID_W-1:0]          c_id;
  logic [NUM_GRP-1:0]       c_pv, c_pe;
  logic [NUM_GRP*LEN_W-1:0] c_pl;

  assign {c_vld, c_id, c_proto, c_pv, c_pl, c_pe} = ctrl_q[3];

  logic                     vld_q, proto_q;
  logic [ID_W-1:0]          id_q;
  logic [SZ_W-1:0]          size_q;
  logic [DW-1:0]            dat_q;
  logic [NUM_GRP-1:0]       pv_q, pe_q;
  logic [NUM_GRP*LEN_W-1:0] pl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      id_q    <= '0;
      size_q  <= '0;
      dat_q   <= '0;
      proto_q <= 1'b0;
      pv_q    <= '0;
      pl_q    <= '0;
      pe_q    <= '0;
    end else begin
      vld_q   <= c_vld;
      id_q    <= c_id;
      size_q  <= c_vld ? size4_q : '0;
      dat_q   <= c_vld ? mask_c : '0;
      proto_q <= c_proto;
      pv_q    <= c_pv;
      pl_q    <= c_pl;
      pe_q    <= c_pe;
    end
  end

  assign o_vld       = vld_q;
  assign o_id        = id_q;
  assign o_size      = size_q;
  assign o_dat       = dat_q;
  assign o_proto_err = proto_q;
  assign o_pkt_vld   = pv_q;
  assign o_pkt_len   = pl_q;
  assign o_pkt_err   = pe_q;

endmodule

// File: tb/tb_dcmac_0_axis_pkt_mon_seg_compact.sv
// Bench for dcmac_0_axis_pkt_mon_seg_compact: directed and random beats vs. a byte-queue model,
// with the length-tracking expectations following DCMAC_PKT_MON_LEN_TRACK_EN.
module tb_dcmac_0_axis_pkt_mon_seg_compact;

  localparam int LAT = 5;

  logic          clk, rst;
  logic          i_vld;
  logic [2:0]    i_id;
  logic [11:0]   i_ena, i_sop, i_eop, i_err;
  logic [47:0]   i_mty;
  logic [1535:0] i_dat;
  logic          o_vld;
  logic [2:0]    o_id;
  logic [7:0]    o_size;
  logic [1535:0] o_dat;
  logic          o_proto_err;
  logic [2:0]    o_pkt_vld;
  logic [47:0]   o_pkt_len;
  logic [2:0]    o_pkt_err;

  dcmac_0_axis_pkt_mon_seg_compact dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_id(i_id), .i_ena(i_ena), .i_sop(i_sop),
    .i_eop(i_eop), .i_err(i_err), .i_mty(i_mty), .i_dat(i_dat), .o_vld(o_vld),
    .o_id(o_id), .o_size(o_size), .o_dat(o_dat), .o_proto_err(o_proto_err),
    .o_pkt_vld(o_pkt_vld), .o_pkt_len(o_pkt_len), .o_pkt_err(o_pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          vld;
    logic [2:0]    id;
    logic [7:0]    size;
    logic [1535:0] dat;
    logic          dat_dc;
    logic          proto;
    logic [2:0]    pv;
    logic [47:0]   pl;
    logic [2:0]    pe;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_len  [6];
  bit   m_open [6];
  bit   m_err  [6];

  function automatic logic [1535:0] rnd_dat();
    logic [1535:0] d;
    for (int w = 0; w < 48; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < 6; n++) begin
      m_len[n] = 0; m_open[n] = 0; m_err[n] = 0;
    end
  endfunction

  // Expected output of one beat: list the surviving bytes and concatenate them.
  function automatic exp_t model(input logic v, input int id, input logic [11:0] ena, sop, eop,
                                 err, input logic [47:0] mty, input logic [1535:0] d,
                                 input logic dc);
    exp_t e;
    logic [7:0] bytes[$];
    bit first_eop[12];
    int seg_len[12];
    int neop;
    bit gap;
    int len;
    bit open, perr;
    e = '0;
    if (!v) return e;
    e.vld = 1'b1;
    e.id = 3'(id);
    e.dat_dc = dc;
    for (int g = 0; g < 3; g++) begin
      neop = 0;
      for (int k = 0; k < 4; k++) begin
        first_eop[g*4+k] = 0;
        if (ena[g*4+k] && eop[g*4+k]) begin
          neop++;
          if (neop == 1) first_eop[g*4+k] = 1;
        end
      end
      if (neop > 1) e.proto = 1'b1;
    end
    gap = 0;
    for (int s = 0; s < 12; s++) begin
      if (!ena[s]) gap = 1;
      else if (gap) e.proto = 1'b1;
    end
    for (int s = 0; s < 12; s++) begin
      seg_len[s] = 16 - (first_eop[s] ? int'(mty[s*4 +: 4]) : 0);
      if (ena[s]) for (int b = 0; b < seg_len[s]; b++) bytes.push_back(d[s*128 + b*8 +: 8]);
    end
    e.size = 8'(bytes.size());
    for (int j = 0; j < bytes.size(); j++) e.dat[j*8 +: 8] = bytes[j];
`ifdef DCMAC_PKT_MON_LEN_TRACK_EN
    if (!e.proto) begin
      len = m_len[id]; open = m_open[id]; perr = m_err[id];
      for (int s = 0; s < 12; s++) begin
        if (!ena[s]) continue;
        if (sop[s]) begin
          perr = open || err[s];
          len = seg_len[s];
          open = 1;
        end else begin
          len = len + seg_len[s];
          if (len > 65535) begin len = 65535; perr = 1; end
          if (err[s]) perr = 1;
        end
        if (first_eop[s]) begin
          e.pv[s/4] = 1'b1;
          e.pl[(s/4)*16 +: 16] = 16'(len);
          e.pe[s/4] = perr || !open;
          len = 0; open = 0; perr = 0;
        end
      end
      m_len[id] = len; m_open[id] = open; m_err[id] = perr;
    end
`else
    len = 0; open = 0; perr = 0;
    if (len != 0 || open || perr || sop != 0 || err != 0) e.pv = '0;
`endif
    return e;
  endfunction

  task automatic check(input exp_t e);
    int fb;
    checks++;
    assert (o_vld === e.vld) else begin
      errors++; $error("FAIL o_vld: got %0b expected %0b", o_vld, e.vld);
    end
    checks++;
    assert (o_id === e.id) else begin
      errors++; $error("FAIL o_id: got %0d expected %0d", o_id, e.id);
    end
    checks++;
    assert (o_size === e.size) else begin
      errors++; $error("FAIL o_size: got %0d expected %0d", o_size, e.size);
    end
    if (!e.dat_dc) begin
      checks++;
      assert (o_dat === e.dat) else begin
        errors++;
        fb = 0;
        for (int b = 191; b >= 0; b--) if (o_dat[b*8 +: 8] !== e.dat[b*8 +: 8]) fb = b;
        $error("FAIL o_dat: byte %0d got %02h expected %02h", fb, o_dat[fb*8 +: 8], e.dat[fb*8 +: 8]);
      end
    end
    checks++;
    assert (o_proto_err === e.proto) else begin
      errors++; $error("FAIL o_proto_err: got %0b expected %0b", o_proto_err, e.proto);
    end
    checks++;
    assert (o_pkt_vld === e.pv) else begin
      errors++; $error("FAIL o_pkt_vld: got %03b expected %03b", o_pkt_vld, e.pv);
    end
    checks++;
    assert (o_pkt_len === e.pl) else begin
      errors++; $error("FAIL o_pkt_len: got %012h expected %012h", o_pkt_len, e.pl);
    end
    checks++;
    assert (o_pkt_err === e.pe) else begin
      errors++; $error("FAIL o_pkt_err: got %03b expected %03b", o_pkt_err, e.pe);
    end
  endtask

  // One clock: check the beat that entered LAT cycles ago, then drive the next one.
  task automatic send(input logic v, input int id, input logic [11:0] ena, sop, eop, err,
                      input logic [47:0] mty, input logic dc);
    logic [1535:0] d;
    @(negedge clk);
    rst = 1'b0;
    if (exp_q.size() == LAT) check(exp_q.pop_front());
    d = rnd_dat();
    i_vld = v; i_id = 3'(id); i_ena = ena; i_sop = sop; i_eop = eop; i_err = err;
    i_mty = mty; i_dat = d;
    exp_q.push_back(model(v, id, ena, sop, eop, err, mty, d, dc));
  endtask

  task automatic idle();
    send(1'b0, 0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_vld = 1'b0; i_id = '0; i_ena = '0; i_sop = '0; i_eop = '0; i_err = '0; i_mty = '0;
    #1;
    check('0);
    model_reset();
    exp_q.delete();
    for (int n = 0; n < LAT; n++) exp_q.push_back('0);
  endtask

  task automatic rnd_beat();
    logic [11:0] ena, sop, eop, err;
    int nen, k;
    nen = $urandom_range(1, 12);
    ena = '0; sop = '0; eop = '0; err = '0;
    for (int s = 0; s < nen; s++) begin
      ena[s] = 1'b1;
      sop[s] = ($urandom_range(0, 3) == 0);
      err[s] = ($urandom_range(0, 15) == 0);
    end
    for (int g = 0; g < 3; g++) begin
      k = $urandom_range(0, 5);
      if (k < 4 && g*4+k < nen) eop[g*4+k] = 1'b1;
    end
    send(($urandom_range(0, 9) < 8), $urandom_range(0, 5), ena, sop, eop, err,
         {$urandom, $urandom}, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    i_vld = 1'b0; i_id = '0; i_ena = '0; i_sop = '0; i_eop = '0; i_err = '0;
    i_mty = '0; i_dat = '0;
    model_reset();
    do_reset();

    // full beat, eop on seg 11 with mty 5
    send(1, 0, 12'hFFF, 12'h001, 12'h800, 12'h000, 48'h500000000000, 0);
    idle(); idle();
    // three packets, eops on segs 1/5/9 with mty 3/7/15, segs 10-11 disabled
    send(1, 1, 12'h3FF, 12'h045, 12'h222, 12'h000, 48'h00F000700030, 0);
    // ID 2 packet across three beats interleaved with ID 4 traffic
    send(1, 2, 12'hFFF, 12'h001, 12'h000, 12'h000, 48'h0, 0);
    send(1, 4, 12'hFFF, 12'h001, 12'h800, 12'h000, 48'h0, 0);
    send(1, 2, 12'hFFF, 12'h000, 12'h000, 12'h000, 48'h0, 0);
    send(1, 4, 12'h00F, 12'h001, 12'h008, 12'h000, 48'h000000004000, 0);
    send(1, 2, 12'h00F, 12'h000, 12'h008, 12'h000, 48'h0, 0);
    // two eops in group 0, then a clean beat
    send(1, 3, 12'hFFF, 12'h001, 12'h003, 12'h000, 48'h000000000092, 0);
    send(1, 3, 12'hFFF, 12'h001, 12'h800, 12'h000, 48'h900000000000, 0);
    // non-contiguous ena: data is don't-care, flag and size still defined
    send(1, 0, 12'hF0F, 12'h000, 12'h000, 12'h000, 48'h0, 1);
    // err flag and sop-while-open
    send(1, 1, 12'h0FF, 12'h011, 12'h080, 12'h002, 48'h0000A0000000, 0);
    idle();
    // reset with three beats in flight; ID 1 continuation then has no open packet
    send(1, 1, 12'hFFF, 12'h001, 12'h000, 12'h000, 48'h0, 0);
    send(1, 1, 12'hFFF, 12'h000, 12'h000, 12'h000, 48'h0, 0);
    send(1, 1, 12'hFFF, 12'h000, 12'h000, 12'h000, 48'h0, 0);
    do_reset();
    send(1, 1, 12'h00F, 12'h000, 12'h008, 12'h000, 48'h000000002000, 0);
    for (int n = 0; n < 6; n++) idle();

    for (int n = 0; n < 300; n++) rnd_beat();

    // length saturation on ID 5
    send(1, 5, 12'hFFF, 12'h001, 12'h000, 12'h000, 48'h0, 0);
    for (int n = 0; n < 345; n++) send(1, 5, 12'hFFF, 12'h000, 12'h000, 12'h000, 48'h0, 0);
    send(1, 5, 12'h001, 12'h000, 12'h001, 12'h000, 48'h3, 0);

    for (int n = 0; n < LAT + 2; n++) idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
